// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction loader.
// State enum, word size and default memory depth.
package inst_loader_pkg;

  localparam int WORD_BYTES    = 4;
  localparam int DEFAULT_DEPTH = 256;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/inst_loader_asm.sv
// Byte-to-word assembler: little-endian shift register with a byte counter.
// word_valid pulses combinationally with the byte that completes a word.
module inst_loader_asm
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam int SH_W  = 8 * (WORD_BYTES - 1);

  logic [CNT_W-1:0] byte_cnt;
  logic [SH_W-1:0]  shreg;

  // Only the first three bytes need storing; the fourth arrives on in_data.
  assign word_valid = take && (byte_cnt == CNT_W'(WORD_BYTES - 1));
  assign word       = {in_data, shreg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (take) begin
      byte_cnt <= byte_cnt + CNT_W'(1);
      shreg    <= {in_data, shreg[SH_W-1:8]};
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: writes a length-prefixed byte stream into instruction memory
// and holds the CPU in reset until done. Trailing checksum enabled by INST_LOADER_CHECKSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = ADDR_W + 1;

  state_t           state, state_nxt;
  logic             take, word_valid, restart, armed, last_word;
  logic [31:0]      word;
  logic [CNT_W-1:0] word_cnt, n_words;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CSUM;
  logic [31:0] csum;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  assign take      = in_valid && in_ready;
  assign restart   = start && (state == ST_DONE || state == ST_ERR);
  assign last_word = (word_cnt + CNT_W'(1)) == n_words;

  inst_loader_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (restart),
    .take      (take),
    .in_data   (in_data),
    .word_valid(word_valid),
    .word      (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_LEN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LEN: begin
        if (word_valid) begin
          if (word > 32'(DEPTH))  state_nxt = ST_ERR;
          else if (word == '0)    state_nxt = ST_AFTER_DATA;
          else                    state_nxt = ST_DATA;
        end
      end
      ST_DATA:  if (word_valid && last_word) state_nxt = ST_AFTER_DATA;
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CSUM:  if (word_valid) state_nxt = (word == csum) ? ST_DONE : ST_ERR;
`endif
      ST_DONE,
      ST_ERR:   if (start) state_nxt = ST_LEN;
      default:  state_nxt = ST_LEN;
    endcase
  end

  // armed keeps in_ready low until the first edge after reset release.
  always_comb begin
    in_ready = 1'b0;
    cpu_rst  = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      ST_LEN, ST_DATA, ST_CSUM: in_ready = armed;
      ST_DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      ST_ERR:  error = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_cnt   <= '0;
      n_words    <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      armed   <= 1'b1;
      imem_we <= 1'b0;
      if (restart) begin
        word_cnt <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end else if (word_valid && state == ST_LEN) begin
        n_words <= word[CNT_W-1:0];
      end else if (word_valid && state == ST_DATA) begin
        imem_we    <= 1'b1;
        imem_addr  <= word_cnt[ADDR_W-1:0];
        imem_wdata <= word;
        word_cnt   <= word_cnt + CNT_W'(1);
`ifdef INST_LOADER_CHECKSUM_EN
        csum       <= csum + word;
`endif
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed scenarios plus randomized loads
// compared against a stream-level reference model.
module tb_inst_loader;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);
`ifdef INST_LOADER_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready, imem_we, cpu_rst, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  inst_loader #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  stim[$];
  logic [31:0] payload[$];
  int          accepted;
  bit          stalled;

  int          mon_addr[$];
  logic [31:0] mon_data[$];
  int          dbl;
  logic        prev_we = 1'b0;
  logic        after_done, after_cpu;

  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_status;    // 0 still loading, 1 done, 2 error
  int          exp_consumed;

  always @(negedge clk) begin
    if (imem_we) begin
      mon_addr.push_back(int'(imem_addr));
      mon_data.push_back(imem_wdata);
      if (prev_we) dbl++;
    end
    if (!imem_we && prev_we) begin
      after_done = done;
      after_cpu  = cpu_rst;
    end
    prev_we = imem_we;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) stim.push_back(w[8*b +: 8]);
  endtask

  // cks_mode: 0 correct sum, 1 all-zero word, 2 corrupted sum
  task automatic build_stream(input int cks_mode);
    logic [31:0] sum;
    sum = '0;
    stim.delete();
    push_word(32'(payload.size()));
    foreach (payload[i]) begin
      push_word(payload[i]);
      sum += payload[i];
    end
    if (cks_mode == 0)      push_word(sum);
    else if (cks_mode == 1) push_word(32'h0);
    else                    push_word(sum ^ (32'h1 << $urandom_range(0, 31)));
  endtask

  task automatic model_run();
    longint n;
    int avail;
    logic [31:0] sum, w;
    exp_addr.delete();
    exp_data.delete();
    sum = '0;
    if (stim.size() < 4) begin
      exp_status = 0; exp_consumed = stim.size(); return;
    end
    n = longint'({stim[3], stim[2], stim[1], stim[0]});
    if (n > DEPTH) begin
      exp_status = 2; exp_consumed = 4; return;
    end
    avail = (stim.size() - 4) / 4;
    for (int i = 0; i < n && i < avail; i++) begin
      w = {stim[4+4*i+3], stim[4+4*i+2], stim[4+4*i+1], stim[4+4*i]};
      exp_addr.push_back(i);
      exp_data.push_back(w);
      sum += w;
    end
    if (avail < n) begin
      exp_status = 0; exp_consumed = stim.size(); return;
    end
    if (!CKS) begin
      exp_status = 1; exp_consumed = 4 + 4*int'(n); return;
    end
    if (stim.size() < 8 + 4*n) begin
      exp_status = 0; exp_consumed = stim.size(); return;
    end
    w = {stim[4+4*n+3], stim[4+4*n+2], stim[4+4*n+1], stim[4+4*n]};
    exp_status   = (w == sum) ? 1 : 2;
    exp_consumed = 8 + 4*int'(n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic begin_load();
    mon_addr.delete();
    mon_data.delete();
    dbl = 0;
    accepted = 0;
    stalled = 1'b0;
  endtask

  // gap_mode: 0 none, 1 idle cycle before every byte, 2 random idles
  task automatic drive(input int from, input int to, input int gap_mode);
    for (int i = from; i < to && !stalled; i++) begin
      int t;
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = stim[i];
      t = 0;
      while (!in_ready && t < 6) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) stalled = 1'b1;
      else begin
        @(negedge clk);
        accepted++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_load(input string name);
    int nmin;
    model_run();
    repeat (3) @(negedge clk);
    checks++;
    if (accepted !== exp_consumed)
      $display("FAIL %s accepted: got %0d expected %0d", name, accepted, exp_consumed);
    checks++;
    if (mon_addr.size() != exp_addr.size())
      $display("FAIL %s write_count: got %0d expected %0d", name, mon_addr.size(), exp_addr.size());
    nmin = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
    for (int i = 0; i < nmin; i++) begin
      checks++;
      if (mon_addr[i] !== exp_addr[i] || mon_data[i] !== exp_data[i]) begin
        failures++;
        $display("FAIL %s write%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                 name, i, mon_addr[i], mon_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (dbl !== 0)
      $display("FAIL %s we_width: got %0d multi-cycle pulses expected 0", name, dbl);
    checks++;
    if ({done, error, cpu_rst, in_ready} !==
        {exp_status == 1, exp_status == 2, exp_status != 1, exp_status == 0})
      $display("FAIL %s status: got done=%b error=%b cpu_rst=%b in_ready=%b expected status %0d",
               name, done, error, cpu_rst, in_ready, exp_status);
    if (accepted !== exp_consumed) failures++;
    if (mon_addr.size() != exp_addr.size()) failures++;
    if (dbl !== 0) failures++;
    if ({done, error, cpu_rst, in_ready} !==
        {exp_status == 1, exp_status == 2, exp_status != 1, exp_status == 0}) failures++;
  endtask

  task automatic test_reset();
    logic [5+ADDR_W+32-1:0] exp_vec;
    exp_vec = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ADDR_W'(0), 32'h0};
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, cpu_rst, imem_we, done, error, imem_addr, imem_wdata} !== exp_vec) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h",
               {in_ready, cpu_rst, imem_we, done, error, imem_addr, imem_wdata}, exp_vec);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed_n2();
    do_reset();
    payload = '{32'h00000013, 32'h002101B3};
    build_stream(0);
    begin_load();
    drive(0, stim.size(), 0);
    check_load("n2_load");
    checks++;
    if (mon_data.size() != 2 || mon_data[0] !== 32'h00000013 || mon_data[1] !== 32'h002101B3) begin
      failures++;
      $display("FAIL n2_values: got %0d writes first=%h expected 00000013 002101B3",
               mon_data.size(), (mon_data.size() > 0) ? mon_data[0] : 32'hx);
    end
    checks++;
    if ({after_done, after_cpu} !== {~CKS, CKS}) begin
      failures++;
      $display("FAIL n2_after_pulse: got done=%b cpu_rst=%b expected done=%b cpu_rst=%b",
               after_done, after_cpu, ~CKS, CKS);
    end
    do_reset();
    build_stream(1);
    begin_load();
    drive(0, stim.size(), 0);
    check_load("n2_zero_checksum");
  endtask

  task automatic test_len_overflow();
    do_reset();
    stim = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    begin_load();
    drive(0, stim.size(), 0);
    check_load("len_256");
    do_reset();
    payload.delete();
    for (int i = 0; i < DEPTH; i++) payload.push_back($urandom);
    build_stream(0);
    begin_load();
    drive(0, stim.size(), 0);
    check_load("len_depth");
    do_reset();
    payload.push_back($urandom);
    build_stream(0);
    begin_load();
    drive(0, stim.size(), 0);
    check_load("len_depth_plus1");
    do_reset();
    payload.delete();
    build_stream(0);
    begin_load();
    drive(0, stim.size(), 0);
    check_load("len_zero");
  endtask

  task automatic test_gaps();
    do_reset();
    payload = '{32'h00000013, 32'h002101B3};
    build_stream(0);
    begin_load();
    drive(0, stim.size(), 1);
    check_load("n2_gapped");
  endtask

  task automatic test_reset_mid_load();
    logic [5+ADDR_W+32-1:0] exp_vec;
    exp_vec = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ADDR_W'(0), 32'h0};
    do_reset();
    payload = '{32'h00000013, 32'h002101B3};
    build_stream(0);
    begin_load();
    drive(0, 9, 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, cpu_rst, imem_we, done, error, imem_addr, imem_wdata} !== exp_vec) begin
      failures++;
      $display("FAIL midload_reset_outputs: got %h expected %h",
               {in_ready, cpu_rst, imem_we, done, error, imem_addr, imem_wdata}, exp_vec);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (mon_addr.size() != 1) begin
      failures++;
      $display("FAIL midload_reset_writes: got %0d expected 1", mon_addr.size());
    end
    payload = '{$urandom};
    build_stream(0);
    begin_load();
    drive(0, stim.size(), 0);
    check_load("after_reset_n1");
  endtask

  task automatic test_restart();
    do_reset();
    payload = '{$urandom};
    build_stream(0);
    begin_load();
    drive(0, stim.size(), 0);
    check_load("pre_restart");
    pulse_start();
    checks++;
    if ({cpu_rst, done, in_ready} !== 3'b101) begin
      failures++;
      $display("FAIL restart_state: got cpu_rst=%b done=%b in_ready=%b expected 1 0 1",
               cpu_rst, done, in_ready);
    end
    payload = '{32'hDEADBEEF};
    build_stream(0);
    begin_load();
    drive(0, stim.size(), 0);
    check_load("reload_deadbeef");
    pulse_start();
    payload = '{$urandom, $urandom, $urandom};
    build_stream(0);
    begin_load();
    drive(0, 10, 0);
    pulse_start();
    drive(10, stim.size(), 0);
    check_load("start_mid_data");
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int n;
      if (it % 2 == 0) do_reset();
      else pulse_start();
      n = $urandom_range(0, DEPTH + 1);
      payload.delete();
      for (int i = 0; i < n; i++) payload.push_back($urandom);
      build_stream(($urandom_range(0, 2) == 0) ? 2 : 0);
      for (int k = $urandom_range(0, 3); k > 0; k--) stim.push_back(8'($urandom_range(0, 255)));
      begin_load();
      drive(0, stim.size(), $urandom_range(0, 2));
      check_load($sformatf("random%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_directed_n2();
    test_len_overflow();
    test_gaps();
    test_reset_mid_load();
    test_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter DEPTH, default 256: instruction-memory capacity in 32-bit words.
REQ-002 Parameter ADDR_W, default $clog2(DEPTH): width of the word address.
REQ-003 Ports, in order:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; re-arms a load from DONE or ERR.
- in_data  input  8  byte stream data.
- in_valid  input  1  byte valid.
- in_ready  output  1  loader accepts a byte.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  word data.
- cpu_rst  output  1  holds the processor in reset while loading.
- done  output  1  load completed successfully.
- error  output  1  load failed.

Function
REQ-004 A byte is accepted on a rising edge only when in_valid and in_ready are both 1.
REQ-005 FSM states: LEN, DATA, CSUM, DONE, ERR.
REQ-006 in_ready is 1 in LEN, DATA and CSUM, and 0 in DONE and ERR.
REQ-007 Stream format:
- 4-byte word count N.
- N data words of 4 bytes each.
- 4-byte checksum, only when the checksum feature is compiled in.
- Every field is little-endian: first byte goes to bits 7:0.
REQ-008 LEN transitions after its 4th accepted byte:
- N > DEPTH: go to ERR.
- N == 0: go to CSUM (checksum feature in) or DONE (feature out).
- Otherwise: go to DATA.
REQ-009 In DATA, each 4th accepted byte completes a word and triggers a write.
- imem_we is 1 for exactly one cycle, in the cycle after that byte is accepted.
- imem_addr equals the word index (0, 1, ..., N-1).
- imem_wdata equals the assembled word.
REQ-010 After word N-1 is accepted, the FSM leaves DATA on the same edge.
- Next state is CSUM (feature in) or DONE (feature out).
- The final imem_we pulse occurs in the first cycle of the new state.
REQ-011 imem_we is 0 in every cycle other than the cycles defined in REQ-009 and REQ-010.
REQ-012 Outputs in DONE: done=1, cpu_rst=0, error=0.
REQ-013 Outputs in ERR: error=1, cpu_rst=1, done=0.
REQ-014 Outputs in all other states: cpu_rst=1, done=0, error=0.
REQ-015 start has an effect only in DONE or ERR.
- On that edge: go to LEN, clear the byte, word and checksum counters, and set cpu_rst=1.
- In any other state, start is ignored.
REQ-016 imem_addr and imem_wdata hold their last values when imem_we is 0.
REQ-017 Gaps in in_valid stall the FSM with no state change or timeout.

Reset
REQ-018 While rst=1, the following hold, asynchronously:
- State = LEN.
- cpu_rst=1, in_ready=0, imem_we=0.
- done=0, error=0.
- imem_addr=0, imem_wdata=0.
- All counters and the checksum accumulator = 0.
REQ-019 in_ready rises in the first cycle after rst is deasserted.
REQ-020 Reset asserted mid-load abandons the partial load; no further imem_we pulse occurs.

Configuration
REQ-021 Macro INST_LOADER_CHECKSUM_EN:
- Defined: a 32-bit accumulator sums all N data words modulo 2^32. CSUM accepts 4 bytes and compares them to the accumulator on the 4th. Match goes to DONE; mismatch goes to ERR.
- Undefined: no CSUM state and no accumulator, and stream bytes after word N-1 are never accepted.

Structure
REQ-022 Package inst_loader_pkg holds:
- The FSM state enum.
- Constant WORD_BYTES=4.
- The default DEPTH.
REQ-023 Sub-module inst_loader_asm is the byte-to-word assembler.
- Contains the shift register and the 2-bit byte counter.
- Outputs word_valid for one cycle per 4 accepted bytes.
REQ-024 The processor top instantiates inst_loader in front of the instruction-memory write port and gates the processor reset with cpu_rst.

Verification
REQ-025 The bench covers these directed scenarios:
- Load N=2 (bytes 02 00 00 00, 13 00 00 00, B3 01 21 00): exactly two imem_we pulses with addr0=00000013 and addr1=002101B3. Then done=1 and cpu_rst=0 the cycle after the 2nd pulse (checksum feature out).
- Feature in, same payload plus checksum C6 01 21 00: done=1. The same payload with checksum 00 00 00 00: error=1, cpu_rst=1, and no done.
- Length 00 01 00 00 (256) with DEPTH=16: ERR after the 4th byte and no imem_we pulse.
- in_valid toggling every other cycle during the N=2 load: identical writes and identical final state.
- rst pulsed after 5 payload bytes: all outputs at reset values. A following full N=1 load succeeds with addr0 written.
- start in DONE reloads N=1 word DEADBEEF: cpu_rst re-asserts, one write to addr0, then done=1 again. start pulsed mid-DATA has no effect.
